// File: rtl/instr_encoder_if.sv
// ---------------------------------------------------------------------------
// instr_encoder_if
// Purpose : bundles the field-set input handshake and the encoded-word output
//           handshake of instr_encoder.
// Signals : in_valid/in_ready   field set offered / encoder can accept
//           op, fmt, rf, ra, rb, func, imm   instruction fields
//           out_valid/out_ready FIFO head valid / consumer takes head
//           instruction         FIFO head word
// Modports: slave  - the encoder (consumes fields, produces words)
//           master - the producer/consumer driving the encoder
// ---------------------------------------------------------------------------
interface instr_encoder_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [1:0]   fmt;
    logic [4:0]   rf;
    logic [4:0]   ra;
    logic [4:0]   rb;
    logic [1:0]   func;
    logic [N-1:0] imm;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] instruction;

    modport slave (
        input  in_valid, op, fmt, rf, ra, rb, func, imm, out_ready,
        output in_ready, out_valid, instruction
    );

    modport master (
        output in_valid, op, fmt, rf, ra, rb, func, imm, out_ready,
        input  in_ready, out_valid, instruction
    );
endinterface

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
// Purpose : encodes instruction fields into the 32-bit layout the decode stage
//           expects, rejects out-of-range immediates / illegal formats, and
//           buffers accepted words in a DEPTH-entry FIFO.
//             R: {op, rf, ra, rb, 12'b0, func}
//             I: {op, rf, ra, imm[18:0]}
//             J: {op, imm[28:0]}
// Ports   : clk        rising-edge clock
//           reset      synchronous, active-low reset
//           bus        instr_encoder_if.slave (input fields + output word)
//           err        one-cycle pulse after a rejected field set
//           err_sticky set by any rejection, cleared only by reset
//           count      number of words accepted into the FIFO (wraps)
// Config  : ENC_BYPASS_EN - when defined, a full FIFO still accepts a push on
//           the same edge as a pop (in_ready = !full || out_ready). When
//           undefined, in_ready = !full and is fully registered.
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_encoder_if.slave        bus,
    output logic                  err,
    output logic                  err_sticky,
    output logic [CW-1:0]         count
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    // Pack the fields into the decode-stage layout; illegal formats give zero.
    function automatic logic [N-1:0] encode_word(
        input logic [2:0]   op,
        input logic [1:0]   fmt,
        input logic [4:0]   rf,
        input logic [4:0]   ra,
        input logic [4:0]   rb,
        input logic [1:0]   func,
        input logic [N-1:0] imm
    );
        logic [N-1:0] word;
        case (fmt)
            2'd0:    word = {op, rf, ra, rb, 12'b0, func};
            2'd1:    word = {op, rf, ra, imm[18:0]};
            2'd2:    word = {op, imm[28:0]};
            default: word = {N{1'b0}};
        endcase
        return word;
    endfunction

    // An immediate is legal only if it fits the field its format provides.
    function automatic logic imm_legal(
        input logic [1:0]   fmt,
        input logic [N-1:0] imm
    );
        logic ok;
        case (fmt)
            2'd0:    ok = 1'b1;
            2'd1:    ok = (imm[N-1:19] == {(N-19){1'b0}});
            2'd2:    ok = (imm[N-1:29] == {(N-29){1'b0}});
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [OW-1:0] occ_r;
    logic          full_r;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [N-1:0]  instruction_r;
    logic          err_r;
    logic          err_sticky_r;
    logic [CW-1:0] count_r;

    logic          in_ready_s;
    logic          push_s;
    logic          legal_s;
    logic          wr_s;
    logic          pop_s;
    logic [N-1:0]  word_s;
    logic [AW-1:0] rd_ptr_inc_s;
    logic [OW-1:0] occ_next_s;
    logic [N-1:0]  head_next_s;

    // Handshake decode, next occupancy and the word that will sit at the head.
    always_comb begin
`ifdef ENC_BYPASS_EN
        in_ready_s = in_ready_r | (full_r & bus.out_ready);
`else
        in_ready_s = in_ready_r;
`endif
        push_s       = bus.in_valid & in_ready_s;
        legal_s      = imm_legal(bus.fmt, bus.imm);
        wr_s         = push_s & legal_s;
        pop_s        = out_valid_r & bus.out_ready;
        word_s       = encode_word(bus.op, bus.fmt, bus.rf, bus.ra, bus.rb,
                                   bus.func, bus.imm);
        rd_ptr_inc_s = rd_ptr_r + AW'(1);

        case ({wr_s, pop_s})
            2'b10:   occ_next_s = occ_r + OW'(1);
            2'b01:   occ_next_s = occ_r - OW'(1);
            default: occ_next_s = occ_r;
        endcase

        // Head is registered: after a pop the next stored entry (or the word
        // being written when the FIFO held only one) moves up; a push into an
        // empty FIFO lands at the head one cycle later, never combinationally.
        head_next_s = instruction_r;
        if (pop_s) begin
            if (occ_r > OW'(1)) begin
                head_next_s = mem[rd_ptr_inc_s];
            end else if (wr_s) begin
                head_next_s = word_s;
            end else begin
                head_next_s = instruction_r;
            end
        end else if ((occ_r == OW'(0)) && wr_s) begin
            head_next_s = word_s;
        end else begin
            head_next_s = instruction_r;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates their use.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem[wr_ptr_r] <= word_s;
        end
    end

    // Pointers, occupancy, registered outputs and error/count bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_r      <= {AW{1'b0}};
            wr_ptr_r      <= {AW{1'b0}};
            occ_r         <= {OW{1'b0}};
            full_r        <= 1'b0;
            in_ready_r    <= 1'b0;
            out_valid_r   <= 1'b0;
            instruction_r <= {N{1'b0}};
            err_r         <= 1'b0;
            err_sticky_r  <= 1'b0;
            count_r       <= {CW{1'b0}};
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
                count_r  <= count_r + CW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_inc_s;
            end
            occ_r         <= occ_next_s;
            full_r        <= (occ_next_s == OW'(DEPTH));
            in_ready_r    <= (occ_next_s != OW'(DEPTH));
            out_valid_r   <= (occ_next_s != OW'(0));
            instruction_r <= head_next_s;
            err_r         <= push_s & ~legal_s;
            if (push_s && !legal_s) begin
                err_sticky_r <= 1'b1;
            end
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_r;
    assign bus.instruction = instruction_r;
    assign err             = err_r;
    assign err_sticky      = err_sticky_r;
    assign count           = count_r;
endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
// Self-checking bench for instr_encoder: a queue-based reference model tracks
// accepted words, count and error flags; a negedge process compares every
// registered output against it, and directed steps pin known encodings.
// ---------------------------------------------------------------------------
module tb_instr_encoder;
    localparam int N     = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 16;
`ifdef ENC_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          err;
    logic          err_sticky;
    logic [CW-1:0] count;

    instr_encoder_if #(.N(N)) bus ();

    instr_encoder #(.N(N), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .err       (err),
        .err_sticky(err_sticky),
        .count     (count)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] q[$];
    logic [15:0] m_count  = 16'd0;
    bit          m_err    = 1'b0;
    bit          m_sticky = 1'b0;
    bit          m_alive  = 1'b0;
    bit          m_started = 1'b0;
    logic [31:0] m_head   = 32'd0;

    function automatic logic [31:0] model_word(input int op, input int fmt, input int rf,
                                               input int ra, input int rb, input int func,
                                               input longint imm);
        longint w;
        case (fmt)
            0:       w = op * 64'd536870912 + rf * 64'd16777216 + ra * 64'd524288
                         + rb * 64'd16384 + func;
            1:       w = op * 64'd536870912 + rf * 64'd16777216 + ra * 64'd524288 + imm;
            default: w = op * 64'd536870912 + imm;
        endcase
        return w[31:0];
    endfunction

    function automatic bit model_legal(input int fmt, input longint imm);
        if (fmt == 0) return 1'b1;
        if (fmt == 1) return imm < 64'd524288;
        if (fmt == 2) return imm < 64'd536870912;
        return 1'b0;
    endfunction

    function automatic bit exp_ready();
        return m_alive && ((q.size() < DEPTH) || (BYP && bus.out_ready));
    endfunction

    always @(posedge clk) begin
        bit acc;
        bit pop;
        if (!reset) begin
            q.delete();
            m_count  = 16'd0;
            m_err    = 1'b0;
            m_sticky = 1'b0;
            m_alive  = 1'b0;
            m_head   = 32'd0;
        end else begin
            acc   = bus.in_valid && exp_ready();
            pop   = (q.size() > 0) && bus.out_ready;
            m_err = 1'b0;
            if (pop) void'(q.pop_front());
            if (acc) begin
                if (model_legal(int'(bus.fmt), longint'(bus.imm))) begin
                    q.push_back(model_word(int'(bus.op), int'(bus.fmt), int'(bus.rf),
                                           int'(bus.ra), int'(bus.rb), int'(bus.func),
                                           longint'(bus.imm)));
                    m_count = m_count + 16'd1;
                end else begin
                    m_err    = 1'b1;
                    m_sticky = 1'b1;
                end
            end
            if (q.size() > 0) m_head = q[0];
            m_alive = 1'b1;
        end
        m_started = 1'b1;
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        if (m_started) begin
            check("out_valid",   bus.out_valid,   q.size() != 0);
            check("instruction", bus.instruction, m_head);
            check("count",       count,           m_count);
            check("err",         err,             m_err);
            check("err_sticky",  err_sticky,      m_sticky);
            check("in_ready",    bus.in_ready,    exp_ready());
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_fields(input logic [2:0] op, input logic [1:0] fmt, input logic [4:0] rf,
                              input logic [4:0] ra, input logic [4:0] rb, input logic [1:0] func,
                              input logic [31:0] imm);
        bus.op = op; bus.fmt = fmt; bus.rf = rf; bus.ra = ra; bus.rb = rb;
        bus.func = func; bus.imm = imm;
    endtask

    task automatic send(input logic [2:0] op, input logic [1:0] fmt, input logic [4:0] rf,
                        input logic [4:0] ra, input logic [4:0] rb, input logic [1:0] func,
                        input logic [31:0] imm);
        int n;
        set_fields(op, fmt, rf, ra, rb, func, imm);
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            total++;
            $display("FAIL send_timeout: waited %0d cycles, limit 20", n);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_fields(3'd0, 2'd0, 5'd0, 5'd0, 5'd0, 2'd0, 32'd0);
        reset = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_count",     count,         16'd0);
        check("rst_in_ready",  bus.in_ready,  1'b0);
        reset = 1'b1;
        tick();

        // 1. R-format
        bus.out_ready = 1'b1;
        send(3'b010, 2'd0, 5'd5, 5'd3, 5'd7, 2'b01, 32'd0);
        @(negedge clk);
        check("t1_word",  bus.instruction, 32'h4519C001);
        check("t1_valid", bus.out_valid,   1'b1);
        check("t1_count", count,           16'd1);
        tick();

        // 2. I-format, in range then out of range
        send(3'b001, 2'd1, 5'd1, 5'd2, 5'd0, 2'd0, 32'h0007FFFF);
        @(negedge clk);
        check("t2_word",  bus.instruction, 32'h2117FFFF);
        check("t2_count", count,           16'd2);
        tick();
        send(3'b001, 2'd1, 5'd1, 5'd2, 5'd0, 2'd0, 32'h00080000);
        @(negedge clk);
        check("t2_err",    err,           1'b1);
        check("t2_sticky", err_sticky,    1'b1);
        check("t2_nocnt",  count,         16'd2);
        check("t2_noword", bus.out_valid, 1'b0);
        tick();
        @(negedge clk);
        check("t2_err_pulse", err,        1'b0);
        check("t2_sticky2",   err_sticky, 1'b1);

        // 3. J-format, out-of-range J, illegal format
        send(3'b111, 2'd2, 5'd0, 5'd0, 5'd0, 2'd0, 32'h1FFFFFFF);
        @(negedge clk);
        check("t3_word",  bus.instruction, 32'hFFFFFFFF);
        check("t3_count", count,           16'd3);
        tick();
        send(3'b111, 2'd2, 5'd0, 5'd0, 5'd0, 2'd0, 32'h20000000);
        @(negedge clk);
        check("t3_j_err", err,   1'b1);
        check("t3_j_cnt", count, 16'd3);
        tick();
        send(3'b011, 2'd3, 5'd1, 5'd1, 5'd1, 2'd0, 32'd0);
        @(negedge clk);
        check("t3_f3_err", err,   1'b1);
        check("t3_f3_cnt", count, 16'd3);
        tick();

        // 4. fill the FIFO with the consumer stalled
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(3'(i), 2'd0, 5'(i + 1), 5'(i + 2), 5'(i + 3), 2'(i), 32'd0);
        end
        @(negedge clk);
        check("t4_full_ready", bus.in_ready, 1'b0);
        check("t4_count",      count,        16'd7);
        set_fields(3'b110, 2'd2, 5'd0, 5'd0, 5'd0, 2'd0, 32'd5);
        bus.in_valid = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("t4_held_count", count,        16'd7);
        check("t4_held_ready", bus.in_ready, 1'b0);

        // 5. full FIFO, producer and consumer both active
        tick();
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("t5_ready", bus.in_ready, BYP);
        tick();
        @(negedge clk);
        check("t5_count", count,           BYP ? 16'd8 : 16'd7);
        check("t5_head",  bus.instruction, 32'h22190001);
        if (BYP) begin
            bus.in_valid = 1'b0;
        end else begin
            tick();
            bus.in_valid = 1'b0;
        end
        n = 0;
        while (bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            total++;
            $display("FAIL drain_timeout: waited %0d cycles, limit 40", n);
        end
        @(negedge clk);
        check("t5_final_count", count,         16'd8);
        check("t5_drained",     bus.out_valid, 1'b0);

        // 6. reset with words buffered
        bus.out_ready = 1'b0;
        send(3'b100, 2'd2, 5'd0, 5'd0, 5'd0, 2'd0, 32'd1);
        send(3'b100, 2'd2, 5'd0, 5'd0, 5'd0, 2'd0, 32'd2);
        send(3'b100, 2'd2, 5'd0, 5'd0, 5'd0, 2'd0, 32'd3);
        @(negedge clk);
        check("t6_pre_count", count, 16'd11);
        reset = 1'b0;
        tick();
        @(negedge clk);
        check("t6_out_valid", bus.out_valid, 1'b0);
        check("t6_count",     count,         16'd0);
        check("t6_sticky",    err_sticky,    1'b0);
        check("t6_in_ready",  bus.in_ready,  1'b0);
        reset = 1'b1;
        tick();
        send(3'b101, 2'd2, 5'd0, 5'd0, 5'd0, 2'd0, 32'h0000ABCD);
        @(negedge clk);
        check("t6_new_word", bus.instruction, 32'hA000ABCD);
        check("t6_new_cnt",  count,           16'd1);
        bus.out_ready = 1'b1;
        tick();
        @(negedge clk);
        check("t6_only_one", bus.out_valid, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
